mdu_div_frontend: RTL

Request front-end for the RV32M divide path, between the CPU execute stage and the divider. Accepts DIV/DIVU/REM/REMU requests through a valid/ready port and queues them in a small FIFO. Issues each request to the divider using the divider's single-cycle-capture protocol. Resolves signed overflow and non-divide encodings locally, and returns tagged results through a held response register.

---
 rtl/mdu_pkg.sv | 44 ++++
 rtl/mdu_div_frontend_if.sv | 58 +++++
 rtl/mdu_req_fifo.sv | 74 +++++++
 rtl/mdu_div_frontend.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_pkg                                                |
// | Description : Shared constants and types for the RV32M divide        |
// |               request front-end.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mdu_pkg;

    // RV32M divide-family funct3 encodings
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Bit positions inside div_type (funct3[1:0])
    localparam int DIV_TYPE_UNSIGNED_BIT = 0;
    localparam int DIV_TYPE_REM_BIT      = 1;

    // Most negative 32-bit signed value; INT_MIN / -1 is the overflow case
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Front-end FSM states
    typedef enum logic [1:0] {
        FE_IDLE  = 2'd0,
        FE_WAIT  = 2'd1,
        FE_DRAIN = 2'd2
    } fe_state_e;

    // Plain-vector views of the states for the state register
    localparam logic [1:0] ST_IDLE  = FE_IDLE;
    localparam logic [1:0] ST_WAIT  = FE_WAIT;
    localparam logic [1:0] ST_DRAIN = FE_DRAIN;

    // Signed divide of INT_MIN by -1 is resolved locally, never issued
    function automatic logic is_signed_overflow(input logic [2:0]  f3,
                                                input logic [31:0] rs1,
                                                input logic [31:0] rs2);
        return f3[2] && !f3[DIV_TYPE_UNSIGNED_BIT] &&
               (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_frontend_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_div_frontend_if                                    |
// | Description : Request, response and divider-side signals of the      |
// |               divide front-end. slave = front-end, master = the      |
// |               CPU/divider environment around it.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mdu_div_frontend_if #(
    parameter int TAG_W = 5
);
    // CPU request port
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;

    // CPU response port
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_dz;
    logic             resp_illegal;

    // Divider port
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic [1:0]       div_type;
    logic             div_in_valid;
    logic             div_cpu_busy;
    logic [31:0]      div_out;
    logic             div_out_valid;
    logic             div_busy;
    logic             div_exception;

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
        input  resp_ready,
        input  div_out, div_out_valid, div_busy, div_exception,
        output req_ready,
        output resp_valid, resp_data, resp_tag, resp_dz, resp_illegal,
        output div_dividend, div_divisor, div_type, div_in_valid, div_cpu_busy
    );

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
        output resp_ready,
        output div_out, div_out_valid, div_busy, div_exception,
        input  req_ready,
        input  resp_valid, resp_data, resp_tag, resp_dz, resp_illegal,
        input  div_dividend, div_divisor, div_type, div_in_valid, div_cpu_busy
    );
endinterface
`default_nettype wire

// File: rtl/mdu_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_req_fifo                                           |
// | Description : DEPTH-entry request queue of packed                    |
// |               {funct3, rs1, rs2, tag}; head is visible without pop.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mdu_req_fifo #(
    parameter int DEPTH   = 2,
    parameter int ENTRY_W = 72
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ENTRY_W-1:0] i_data,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem_q [DEPTH];
    logic [PTR_W:0]     r_wptr_q, r_rptr_q;
    logic [PTR_W:0]     w_wptr_d, w_rptr_d;
    logic               w_push_en;

    // Extra pointer bit separates full from empty when the indices match
    assign o_empty = (r_wptr_q == r_rptr_q);
    assign o_full  = (r_wptr_q[PTR_W] != r_rptr_q[PTR_W]) &&
                     (r_wptr_q[PTR_W-1:0] == r_rptr_q[PTR_W-1:0]);
    assign o_head  = r_mem_q[r_rptr_q[PTR_W-1:0]];

    // A flush wins over both push and pop in the same cycle
    assign w_push_en = i_push && !o_full && !i_flush;

    // Next-pointer computation
    always_comb begin
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        if (i_flush) begin
            w_wptr_d = '0;
            w_rptr_d = '0;
        end else begin
            if (w_push_en) begin
                w_wptr_d = r_wptr_q + 1'b1;
            end
            if (i_pop && !o_empty) begin
                w_rptr_d = r_rptr_q + 1'b1;
            end
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
        end
    end

    // Storage; contents are only meaningful while the pointers cover them
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem_q[r_wptr_q[PTR_W-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_div_frontend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mdu_div_frontend                                       |
// | Description : RV32M divide request front-end: queues requests,       |
// |               issues them to the divider, resolves overflow and      |
// |               illegal encodings locally, holds tagged responses.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mdu_div_frontend
    import mdu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    mdu_div_frontend_if.slave bus
);
    localparam int ENTRY_W = 3 + 32 + 32 + TAG_W;

    logic [ENTRY_W-1:0] w_push_entry, w_head_entry;
    logic               w_fifo_full, w_fifo_empty, w_push, w_pop;
    logic [2:0]         w_head_f3;
    logic [31:0]        w_head_rs1, w_head_rs2;
    logic [TAG_W-1:0]   w_head_tag;
    logic               w_slot_free, w_head_illegal, w_head_ovf;
    logic               w_issue, w_load, w_cpu_busy;

    logic [1:0]         r_state_q, w_state_d;
    logic               r_resp_valid_q, w_resp_valid_d;
    logic [31:0]        r_resp_data_q, w_resp_data_d;
    logic [TAG_W-1:0]   r_resp_tag_q, w_resp_tag_d;
    logic               r_resp_dz_q, w_resp_dz_d;
    logic               r_resp_ill_q, w_resp_ill_d;
    logic [31:0]        w_load_data;
    logic               w_load_dz, w_load_ill;

    assign w_push       = bus.req_valid && !w_fifo_full;
    assign w_push_entry = {bus.req_funct3, bus.req_rs1, bus.req_rs2, bus.req_tag};
    assign {w_head_f3, w_head_rs1, w_head_rs2, w_head_tag} = w_head_entry;

    mdu_req_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.flush),
        .i_data  (w_push_entry),
        .o_head  (w_head_entry),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_slot_free    = !r_resp_valid_q || bus.resp_ready;
    assign w_head_illegal = !w_head_f3[2];
    assign w_head_ovf     = is_signed_overflow(w_head_f3, w_head_rs1, w_head_rs2);

    // Head-of-queue FSM: local resolution, issue, result capture, drain
    always_comb begin
        w_state_d   = r_state_q;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_load_data = '0;
        w_load_dz   = 1'b0;
        w_load_ill  = 1'b0;
        w_cpu_busy  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (!bus.flush && !w_fifo_empty) begin
                    if (w_head_illegal || w_head_ovf) begin
                        if (w_slot_free) begin
                            w_pop      = 1'b1;
                            w_load     = 1'b1;
                            w_load_ill = w_head_illegal;
                            // Overflow: DIV gives INT_MIN, REM gives 0
                            if (!w_head_illegal && !w_head_f3[DIV_TYPE_REM_BIT]) begin
                                w_load_data = INT_MIN;
                            end
                        end
                    end else if (!bus.div_busy) begin
                        w_issue   = 1'b1;
                        w_state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Keep the divider parked in done while the response slot is occupied
                w_cpu_busy = r_resp_valid_q && !bus.resp_ready;
                if (bus.flush) begin
                    // A result arriving with the flush is dropped on the spot
                    w_state_d = bus.div_out_valid ? ST_IDLE : ST_DRAIN;
                end else if (bus.div_out_valid && w_slot_free) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_load_data = bus.div_out;
                    w_load_dz   = bus.div_exception && (w_head_rs2 == 32'd0);
                    w_state_d   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.div_out_valid) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Response holding register: load wins over consume
    always_comb begin
        w_resp_valid_d = r_resp_valid_q;
        w_resp_data_d  = r_resp_data_q;
        w_resp_tag_d   = r_resp_tag_q;
        w_resp_dz_d    = r_resp_dz_q;
        w_resp_ill_d   = r_resp_ill_q;
        if (w_load) begin
            w_resp_valid_d = 1'b1;
            w_resp_data_d  = w_load_data;
            w_resp_tag_d   = w_head_tag;
            w_resp_dz_d    = w_load_dz;
            w_resp_ill_d   = w_load_ill;
        end else if (bus.resp_ready) begin
            w_resp_valid_d = 1'b0;
        end
    end

    // State and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q      <= ST_IDLE;
            r_resp_valid_q <= 1'b0;
            r_resp_data_q  <= '0;
            r_resp_tag_q   <= '0;
            r_resp_dz_q    <= 1'b0;
            r_resp_ill_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_data_q  <= w_resp_data_d;
            r_resp_tag_q   <= w_resp_tag_d;
            r_resp_dz_q    <= w_resp_dz_d;
            r_resp_ill_q   <= w_resp_ill_d;
        end
    end

    assign bus.req_ready    = !w_fifo_full;
    assign bus.resp_valid   = r_resp_valid_q;
    assign bus.resp_data    = r_resp_data_q;
    assign bus.resp_tag     = r_resp_tag_q;
    assign bus.resp_dz      = r_resp_dz_q;
    assign bus.resp_illegal = r_resp_ill_q;

    // Operands are only driven during the one-cycle issue strobe
    assign bus.div_in_valid = w_issue;
    assign bus.div_dividend = w_issue ? w_head_rs1 : 32'd0;
    assign bus.div_divisor  = w_issue ? w_head_rs2 : 32'd0;
    assign bus.div_type     = w_issue ? w_head_f3[1:0] : 2'd0;
    assign bus.div_cpu_busy = w_cpu_busy;

endmodule
`default_nettype wire
